// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for alu_mc.
// master = requester/consumer side, slave = ALU side.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic [4:0]       flags;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, c, flags
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, c, flags
  );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Ops 000-110 complete in one cycle; 111 (MUL) is a shift-add multiplier
// taking WIDTH cycles when ALU_MC_MUL_EN is defined, otherwise it returns
// c = 0, flags = 0 with single-cycle latency.
// flags = {Z, C, F(signed ovf), L(unsigned lt), N(signed lt)}.
module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic [2:0] {
    OP_ADDU = 3'b000, OP_ADD = 3'b001, OP_SUB = 3'b010, OP_CMP = 3'b011,
    OP_AND  = 3'b100, OP_OR  = 3'b101, OP_XOR = 3'b110, OP_MUL = 3'b111
  } op_t;

`ifdef ALU_MC_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  op_t              op;
  logic             accept;
  logic             mul_start;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] dif_w;
  logic [WIDTH-1:0] alu_c;
  logic [4:0]       alu_f;
  logic             z, cy, ov, lt_u, lt_s;
  logic [WIDTH-1:0] c_q;
  logic [4:0]       flags_q;

  assign op            = op_t'(bus.opcode);
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.c         = c_q;
  assign bus.flags     = flags_q;

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [5:0]         cnt_q;
  logic               mul_last;

  assign mul_start = accept && (op == OP_MUL);
  assign mul_last  = (state_q == BUSY) && (cnt_q == 6'(WIDTH - 1));
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Shift-add datapath: one multiplier bit consumed per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, bus.a};
      mplier_q <= bus.b;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 6'd1;
    end
  end
`else
  assign mul_start = 1'b0;
`endif

  // Single-cycle ALU result and flags from the live request operands.
  always_comb begin
    sum_w = {1'b0, bus.a} + {1'b0, bus.b};
    dif_w = bus.a - bus.b;
    alu_c = '0;
    cy    = 1'b0;
    ov    = 1'b0;
    lt_u  = 1'b0;
    lt_s  = 1'b0;
    case (op)
      OP_ADDU: begin
        alu_c = sum_w[MSB:0];
        cy    = sum_w[WIDTH];
      end
      OP_ADD: begin
        alu_c = sum_w[MSB:0];
        ov    = (bus.a[MSB] == bus.b[MSB]) && (alu_c[MSB] != bus.a[MSB]);
      end
      OP_SUB: begin
        alu_c = dif_w;
        ov    = (bus.a[MSB] != bus.b[MSB]) && (alu_c[MSB] != bus.a[MSB]);
      end
      OP_CMP: begin
        lt_u = bus.a < bus.b;
        lt_s = $signed(bus.a) < $signed(bus.b);
      end
      OP_AND:  alu_c = bus.a & bus.b;
      OP_OR:   alu_c = bus.a | bus.b;
      OP_XOR:  alu_c = bus.a ^ bus.b;
      default: alu_c = '0;
    endcase
    if (op == OP_CMP)      z = (bus.a == bus.b);
    else if (op == OP_MUL) z = 1'b0;
    else                   z = (alu_c == '0);
    alu_f = {z, cy, ov, lt_u, lt_s};
  end

  // Next-state logic; DONE can chain straight into a new op on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = DONE;
`ifdef ALU_MC_MUL_EN
          if (mul_start) state_d = BUSY;
`endif
        end else if ((state_q == DONE) && bus.out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MC_MUL_EN
      BUSY: if (mul_last) state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result registers; only written on completion, so held while DONE stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      flags_q <= '0;
    end else if (accept && !mul_start) begin
      c_q     <= alu_c;
      flags_q <= alu_f;
    end
`ifdef ALU_MC_MUL_EN
    else if (mul_last) begin
      c_q     <= acc_d[MSB:0];
      flags_q <= {(acc_d[MSB:0] == '0), (|acc_d[2*WIDTH-1:WIDTH]), 3'b000};
    end
`endif
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=16) against a
// behavioural arithmetic model; follows ALU_MC_MUL_EN for MUL expectations.
`timescale 1ns/1ps
module tb_alu_mc;
  localparam int unsigned W = 16;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference: {c[15:0], Z, C, F, L, N} from plain integer arithmetic.
  function automatic logic [20:0] model(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv);
    int sa, sb, r;
    longint unsigned p;
    logic [15:0] rc;
    logic z, cy, f, l, n;
    sa = int'(av) - ((av >= 16'h8000) ? 65536 : 0);
    sb = int'(bv) - ((bv >= 16'h8000) ? 65536 : 0);
    rc = '0; cy = 0; f = 0; l = 0; n = 0;
    case (op)
      3'd0: begin r = int'(av) + int'(bv); rc = 16'(r); cy = (r > 65535); end
      3'd1: begin r = sa + sb; rc = 16'(r); f = (r > 32767) || (r < -32768); end
      3'd2: begin r = sa - sb; rc = 16'(r); f = (r > 32767) || (r < -32768); end
      3'd3: begin l = (av < bv); n = (sa < sb); end
      3'd4: rc = av & bv;
      3'd5: rc = av | bv;
      3'd6: rc = av ^ bv;
      default: if (MUL_ON) begin
        p  = longint'(av) * longint'(bv);
        rc = 16'(p);
        cy = ((p >> 16) != 0);
      end
    endcase
    if (op == 3'd3)                z = (av == bv);
    else if (op == 3'd7 && !MUL_ON) z = 1'b0;
    else                           z = (rc == 16'h0);
    return {rc, z, cy, f, l, n};
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    return (op == 3'd7 && MUL_ON) ? int'(W) : 0;
  endfunction

  // Issue one op from IDLE, wait (bounded) for the result, then consume it.
  // lat = edges after the accept edge until out_valid is seen.
  task automatic run_op(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output logic [15:0] cv, output logic [4:0] fv, output int rdy_hi);
    bus.opcode = op; bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.opcode = 3'($urandom);
    lat = 0; rdy_hi = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    cv = bus.c; fv = bus.flags;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat, rh;
    logic [15:0] cv;
    logic [4:0] fv;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.c !== 16'h0) $display("FAIL rst_c got %h want 0000", bus.c); else passed++;
    checks++; if (bus.flags !== 5'b0) $display("FAIL rst_flags got %b want 00000", bus.flags); else passed++;
    #2 rst_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passed++;
    run_op(3'd1, 16'h0001, 16'h0002, lat, cv, fv, rh);
    checks++; if (lat !== 0) $display("FAIL first_req_lat got %0d want 0", lat); else passed++;
    checks++; if (cv !== 16'h0003) $display("FAIL first_req_c got %h want 0003", cv); else passed++;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd3, 3'd7};
    logic [15:0] as  [6] = '{16'h7FFF, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h0005, 16'h0100};
    logic [15:0] bs  [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005, 16'h0100};
    logic [15:0] ecs [6] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    logic [4:0]  efs [6];
    int lat, rh;
    logic [15:0] cv;
    logic [4:0] fv;
    efs = '{5'b00100, 5'b11000, 5'b00100, 5'b00001, 5'b10000, (MUL_ON ? 5'b11000 : 5'b00000)};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat, cv, fv, rh);
      checks++; if (cv !== ecs[i]) $display("FAIL dir%0d_c got %h want %h", i, cv, ecs[i]); else passed++;
      checks++; if (fv !== efs[i]) $display("FAIL dir%0d_flags got %b want %b", i, fv, efs[i]); else passed++;
      checks++; if (lat !== exp_lat(ops[i])) $display("FAIL dir%0d_lat got %0d want %0d", i, lat, exp_lat(ops[i])); else passed++;
      checks++; if (rh !== 0) $display("FAIL dir%0d_busy_ready got %0d want 0", i, rh); else passed++;
    end
  endtask

  task automatic test_random();
    logic [15:0] edge_v [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [2:0]  op;
    logic [15:0] av, bv, cv;
    logic [4:0]  fv;
    logic [20:0] e;
    int lat, rh;
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      av = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
      e  = model(op, av, bv);
      run_op(op, av, bv, lat, cv, fv, rh);
      checks++; if (cv !== e[20:5]) $display("FAIL rnd%0d_c op=%0d a=%h b=%h got %h want %h", i, op, av, bv, cv, e[20:5]); else passed++;
      checks++; if (fv !== e[4:0]) $display("FAIL rnd%0d_flags op=%0d a=%h b=%h got %b want %b", i, op, av, bv, fv, e[4:0]); else passed++;
      checks++; if (lat !== exp_lat(op)) $display("FAIL rnd%0d_lat op=%0d got %0d want %0d", i, op, lat, exp_lat(op)); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] av, bv;
    logic [20:0] e;
    bus.opcode = 3'd4; bus.a = 16'h00F0; bus.b = 16'h0FF0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp%0d_out_valid got %b want 1", i, bus.out_valid); else passed++;
      checks++; if (bus.c !== 16'h00F0) $display("FAIL bp%0d_c got %h want 00f0", i, bus.c); else passed++;
      checks++; if (bus.flags !== 5'b0) $display("FAIL bp%0d_flags got %b want 00000", i, bus.flags); else passed++;
      checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp%0d_in_ready got %b want 0", i, bus.in_ready); else passed++;
      @(posedge clk); #1;
    end
    av = 16'($urandom); bv = 16'($urandom); e = model(3'd6, av, bv);
    bus.opcode = 3'd6; bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_next_valid got %b want 1", bus.out_valid); else passed++;
    checks++; if (bus.c !== e[20:5]) $display("FAIL bp_next_c got %h want %h", bus.c, e[20:5]); else passed++;
    checks++; if (bus.flags !== e[4:0]) $display("FAIL bp_next_flags got %b want %b", bus.flags, e[4:0]); else passed++;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_drain_valid got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [15:0] av, bv;
    logic [20:0] e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 6)); av = 16'($urandom); bv = 16'($urandom);
      e  = model(op, av, bv);
      bus.opcode = op; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL b2b%0d_valid got %b want 1", i, bus.out_valid); else passed++;
      checks++; if ({bus.c, bus.flags} !== e) $display("FAIL b2b%0d_result op=%0d got %h/%b want %h/%b", i, op, bus.c, bus.flags, e[20:5], e[4:0]); else passed++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain_valid got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_reset_mid_mul();
    int lat, rh, seen;
    logic [15:0] cv, av, bv;
    logic [4:0] fv;
    logic [20:0] e;
    run_op(3'd1, 16'h1234, 16'h1111, lat, cv, fv, rh);
    checks++; if (cv !== 16'h2345) $display("FAIL pre_mul_c got %h want 2345", cv); else passed++;
    bus.opcode = 3'd7; bus.a = 16'h0003; bus.b = 16'h0005; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.c !== 16'h0) $display("FAIL midrst_c got %h want 0000", bus.c); else passed++;
    checks++; if (bus.flags !== 5'b0) $display("FAIL midrst_flags got %b want 00000", bus.flags); else passed++;
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst_no_result got %0d valid cycles want 0", seen); else passed++;
    av = 16'($urandom); bv = 16'($urandom); e = model(3'd1, av, bv);
    run_op(3'd1, av, bv, lat, cv, fv, rh);
    checks++; if ({cv, fv} !== e) $display("FAIL post_rst_add got %h/%b want %h/%b", cv, fv, e[20:5], e[4:0]); else passed++;
    checks++; if (lat !== 0) $display("FAIL post_rst_lat got %0d want 0", lat); else passed++;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
